// File: rtl/ahb_pkg.sv
// Shared AHB constants and FSM encoding for the bridge-side arbiters.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_select #(
    parameter int N_MASTERS = 4,
    localparam int IW = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [N_MASTERS-1:0] grant,
    output logic [IW-1:0]        index,
    output logic                 any_req
);

    // slot_idx[k] is the requester examined k-th in priority order
    logic [IW-1:0] slot_idx [N_MASTERS];
    logic          found;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_slot
        assign slot_idx[gi] = IW'((32'(ptr) + 32'(gi)) % 32'(N_MASTERS));
    end

    assign any_req = |req;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && req[slot_idx[k]]) begin
                found                = 1'b1;
                grant[slot_idx[k]]   = 1'b1;
                index                = slot_idx[k];
            end
        end
    end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin arbiter sharing one AHB slave port between N_MASTERS requesters,
// issuing single transfers with a data-phase wait-state watchdog.
module ahb_rr_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MASTERS      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    hclk,
    input  logic                    hresetn,
    input  logic [N_MASTERS-1:0]    req,
    input  logic [N_MASTERS-1:0]    req_write,
    input  logic [32*N_MASTERS-1:0] req_addr,
    input  logic [32*N_MASTERS-1:0] req_wdata,
    output logic [N_MASTERS-1:0]    grant,
    output logic [N_MASTERS-1:0]    done,
    output logic [31:0]             rdata,
    output logic                    err,
    output logic [1:0]              htrans,
    output logic [31:0]             haddr,
    output logic                    hwrite,
    output logic [31:0]             hwdata,
    output logic                    hreadyin,
    input  logic                    hr_readyout,
    input  logic [31:0]             hrdata,
    input  logic [1:0]              hresp
);

    localparam int         IW        = $clog2(N_MASTERS);
    localparam logic [7:0] TIMEOUT_W = 8'(TIMEOUT_CYCLES);

    logic [1:0]           state_reg;
    logic [IW-1:0]        ptr_reg;
    logic [IW-1:0]        owner_reg;
    logic [N_MASTERS-1:0] grant_reg;
    logic [31:0]          haddr_reg;
    logic                 hwrite_reg;
    logic [31:0]          wdata_reg;
    logic [31:0]          hwdata_reg;
    logic [31:0]          rdata_reg;
    logic                 err_reg;
    logic [7:0]           wait_cnt_reg;

    logic [31:0]          addr_arr  [N_MASTERS];
    logic [31:0]          wdata_arr [N_MASTERS];

    logic [N_MASTERS-1:0] sel_grant;
    logic [IW-1:0]        sel_index;
    logic                 sel_any;

    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_unpack
        assign addr_arr[gi]  = req_addr[32*gi +: 32];
        assign wdata_arr[gi] = req_wdata[32*gi +: 32];
    end

    rr_select #(
        .N_MASTERS (N_MASTERS)
    ) u_rr_select (
        .req     (req),
        .ptr     (ptr_reg),
        .grant   (sel_grant),
        .index   (sel_index),
        .any_req (sel_any)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= '0;
            owner_reg    <= '0;
            grant_reg    <= '0;
            haddr_reg    <= '0;
            hwrite_reg   <= 1'b0;
            wdata_reg    <= '0;
            hwdata_reg   <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (sel_any) begin
                        grant_reg  <= sel_grant;
                        owner_reg  <= sel_index;
                        haddr_reg  <= addr_arr[sel_index];
                        hwrite_reg <= req_write[sel_index];
                        wdata_reg  <= wdata_arr[sel_index];
                        err_reg    <= 1'b0;
                        state_reg  <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (hr_readyout) begin
                        hwdata_reg   <= wdata_reg;
                        wait_cnt_reg <= '0;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Ready is tested first so it wins over an expiring watchdog.
                    if (hr_readyout) begin
                        if (!hwrite_reg) begin
                            rdata_reg <= hrdata;
                        end
                        err_reg   <= (hresp != HRESP_OKAY);
                        state_reg <= ST_DONE;
                    end else if (wait_cnt_reg == TIMEOUT_W) begin
                        err_reg   <= 1'b1;
                        rdata_reg <= TIMEOUT_RDATA;
                        state_reg <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    ptr_reg   <= (owner_reg == IW'(N_MASTERS - 1)) ? '0 : owner_reg + IW'(1);
                    grant_reg <= '0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign grant    = grant_reg;
    assign done     = (state_reg == ST_DONE) ? grant_reg : '0;
    assign err      = (state_reg == ST_DONE) && err_reg;
    assign rdata    = rdata_reg;
    assign htrans   = (state_reg == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr    = haddr_reg;
    assign hwrite   = hwrite_reg;
    assign hwdata   = hwdata_reg;
    assign hreadyin = hr_readyout;

endmodule
